// File: rtl/or1200_dmmu_top.sv
// or1200_dmmu_top: data MMU for the OR1200 load/store path.
// Holds a direct-mapped, single-way DTLB that is programmed over SPR accesses.
// Translates CPU virtual data addresses to physical QMEM addresses with no
// added latency. Reports TLB misses and page faults through the tag/err outputs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dc_en, dmmu_en, supv      cache enable, translation enable, supervisor mode
//   dcpu_adr_i/cycstb_i/we_i  CPU access request (virtual address)
//   dcpu_tag_o, dcpu_err_o    access tag/error back to the CPU
//   spr_cs/write/addr/dat_i   SPR access into the DTLB
//   spr_dat_o                 SPR read data (combinational)
//   qmemdmmu_*                downstream (physical) memory interface
module or1200_dmmu_top #(
  parameter int unsigned aw        = 32,
  parameter int unsigned dtlb_sets = 64,
  parameter int unsigned page_bits = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dc_en,
  input  logic          dmmu_en,
  input  logic          supv,
  input  logic [aw-1:0] dcpu_adr_i,
  input  logic          dcpu_cycstb_i,
  input  logic          dcpu_we_i,
  output logic [3:0]    dcpu_tag_o,
  output logic          dcpu_err_o,
  input  logic          spr_cs,
  input  logic          spr_write,
  input  logic [31:0]   spr_addr,
  input  logic [31:0]   spr_dat_i,
  output logic [31:0]   spr_dat_o,
  input  logic          qmemdmmu_err_i,
  input  logic [3:0]    qmemdmmu_tag_i,
  output logic [aw-1:0] qmemdmmu_adr_o,
  output logic          qmemdmmu_cycstb_o,
  output logic          qmemdmmu_ci_o
);

  localparam int unsigned IdxW = $clog2(dtlb_sets);
  localparam int unsigned VpnW = aw - page_bits;

  localparam logic [3:0] TagMiss = 4'hD;
  localparam logic [3:0] TagPf   = 4'hB;

  // Match register fields
  logic [VpnW-1:0] r_mr_vpn [dtlb_sets];
  logic            r_mr_v   [dtlb_sets];
  // Translate register fields
  logic [VpnW-1:0] r_tr_ppn [dtlb_sets];
  logic            r_tr_swe [dtlb_sets];
  logic            r_tr_sre [dtlb_sets];
  logic            r_tr_uwe [dtlb_sets];
  logic            r_tr_ure [dtlb_sets];
  logic            r_tr_ci  [dtlb_sets];

  logic            w_tlb_sel;
  logic            w_sel_tr;
  logic [IdxW-1:0] w_spr_idx;
  logic [IdxW-1:0] w_idx;
  logic            w_hit;
  logic            w_pf;
  logic            w_miss;
  logic            w_pf_err;

  assign w_tlb_sel = spr_cs & spr_addr[9];
  assign w_sel_tr  = spr_addr[7];
  assign w_spr_idx = spr_addr[IdxW-1:0];

  // Address/data bits with no meaning in this block
  logic w_unused;
  assign w_unused = ^{spr_addr[31:10], spr_addr[8], spr_addr[6],
                      spr_dat_i[12:10], spr_dat_i[5:2]};

  // SPR writes and reset. Lookup reads these registers combinationally, so a
  // write in the same cycle as a lookup is seen only from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(dtlb_sets); i++) begin
        r_mr_vpn[i] <= '0;
        r_mr_v[i]   <= 1'b0;
        r_tr_ppn[i] <= '0;
        r_tr_swe[i] <= 1'b0;
        r_tr_sre[i] <= 1'b0;
        r_tr_uwe[i] <= 1'b0;
        r_tr_ure[i] <= 1'b0;
        r_tr_ci[i]  <= 1'b0;
      end
    end else if (w_tlb_sel && spr_write) begin
      if (!w_sel_tr) begin
        r_mr_vpn[w_spr_idx] <= spr_dat_i[31:page_bits];
        r_mr_v[w_spr_idx]   <= spr_dat_i[0];
      end else begin
        r_tr_ppn[w_spr_idx] <= spr_dat_i[31:page_bits];
        r_tr_swe[w_spr_idx] <= spr_dat_i[9];
        r_tr_sre[w_spr_idx] <= spr_dat_i[8];
        r_tr_uwe[w_spr_idx] <= spr_dat_i[7];
        r_tr_ure[w_spr_idx] <= spr_dat_i[6];
        r_tr_ci[w_spr_idx]  <= spr_dat_i[1];
      end
    end
  end

  // SPR read mux; unmapped bits read as zero
  always_comb begin
    spr_dat_o = '0;
    if (w_tlb_sel && !spr_write) begin
      if (!w_sel_tr) begin
        spr_dat_o[31:page_bits] = r_mr_vpn[w_spr_idx];
        spr_dat_o[0]            = r_mr_v[w_spr_idx];
      end else begin
        spr_dat_o[31:page_bits] = r_tr_ppn[w_spr_idx];
        spr_dat_o[9]            = r_tr_swe[w_spr_idx];
        spr_dat_o[8]            = r_tr_sre[w_spr_idx];
        spr_dat_o[7]            = r_tr_uwe[w_spr_idx];
        spr_dat_o[6]            = r_tr_ure[w_spr_idx];
        spr_dat_o[1]            = r_tr_ci[w_spr_idx];
      end
    end
  end

  // Lookup
  assign w_idx = dcpu_adr_i[page_bits +: IdxW];
  assign w_hit = r_mr_v[w_idx] & (r_mr_vpn[w_idx] == dcpu_adr_i[aw-1:page_bits]);

  always_comb begin
    w_pf = 1'b0;
    if (dmmu_en && w_hit) begin
      if (supv) begin
        w_pf = dcpu_we_i ? ~r_tr_swe[w_idx] : ~r_tr_sre[w_idx];
      end else begin
        w_pf = dcpu_we_i ? ~r_tr_uwe[w_idx] : ~r_tr_ure[w_idx];
      end
    end
  end

  assign w_miss   = dmmu_en & dcpu_cycstb_i & ~w_hit;
  assign w_pf_err = w_pf & dcpu_cycstb_i;

  always_comb begin
    if (dmmu_en) begin
      qmemdmmu_adr_o    = {r_tr_ppn[w_idx], dcpu_adr_i[page_bits-1:0]};
      qmemdmmu_cycstb_o = dcpu_cycstb_i & w_hit & ~w_pf;
      qmemdmmu_ci_o     = ~dc_en | r_tr_ci[w_idx];
    end else begin
      qmemdmmu_adr_o    = dcpu_adr_i;
      qmemdmmu_cycstb_o = dcpu_cycstb_i;
      qmemdmmu_ci_o     = ~dc_en;
    end
  end

  always_comb begin
    if (w_miss) begin
      dcpu_tag_o = TagMiss;
    end else if (w_pf_err) begin
      dcpu_tag_o = TagPf;
    end else begin
      dcpu_tag_o = qmemdmmu_tag_i;
    end
  end

  assign dcpu_err_o = w_miss | w_pf_err | qmemdmmu_err_i;

endmodule

// File: tb/tb_or1200_dmmu_top.sv
module tb_or1200_dmmu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        dc_en;
  logic        dmmu_en;
  logic        supv;
  logic [31:0] dcpu_adr_i;
  logic        dcpu_cycstb_i;
  logic        dcpu_we_i;
  logic [3:0]  dcpu_tag_o;
  logic        dcpu_err_o;
  logic        spr_cs;
  logic        spr_write;
  logic [31:0] spr_addr;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;
  logic        qmemdmmu_err_i;
  logic [3:0]  qmemdmmu_tag_i;
  logic [31:0] qmemdmmu_adr_o;
  logic        qmemdmmu_cycstb_o;
  logic        qmemdmmu_ci_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  or1200_dmmu_top dut (
    .clk               (clk),
    .rst               (rst),
    .dc_en             (dc_en),
    .dmmu_en           (dmmu_en),
    .supv              (supv),
    .dcpu_adr_i        (dcpu_adr_i),
    .dcpu_cycstb_i     (dcpu_cycstb_i),
    .dcpu_we_i         (dcpu_we_i),
    .dcpu_tag_o        (dcpu_tag_o),
    .dcpu_err_o        (dcpu_err_o),
    .spr_cs            (spr_cs),
    .spr_write         (spr_write),
    .spr_addr          (spr_addr),
    .spr_dat_i         (spr_dat_i),
    .spr_dat_o         (spr_dat_o),
    .qmemdmmu_err_i    (qmemdmmu_err_i),
    .qmemdmmu_tag_i    (qmemdmmu_tag_i),
    .qmemdmmu_adr_o    (qmemdmmu_adr_o),
    .qmemdmmu_cycstb_o (qmemdmmu_cycstb_o),
    .qmemdmmu_ci_o     (qmemdmmu_ci_o)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        dce;
    logic        sv;
    logic        we;
    logic        cyc;
    logic [31:0] adr;
    logic [3:0]  qtag;
    logic        qerr;
    logic [31:0] e_adr;
    logic        e_cyc;
    logic        e_ci;
    logic [3:0]  e_tag;
    logic        e_err;
  } vec_t;

  vec_t tab_a[3];
  vec_t tab_b[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    dmmu_en        = v.en;
    dc_en          = v.dce;
    supv           = v.sv;
    dcpu_we_i      = v.we;
    dcpu_cycstb_i  = v.cyc;
    dcpu_adr_i     = v.adr;
    qmemdmmu_tag_i = v.qtag;
    qmemdmmu_err_i = v.qerr;
    #2;
    check({v.name, ".adr"}, qmemdmmu_adr_o, v.e_adr);
    check({v.name, ".cyc"}, {31'd0, qmemdmmu_cycstb_o}, {31'd0, v.e_cyc});
    check({v.name, ".ci"},  {31'd0, qmemdmmu_ci_o},     {31'd0, v.e_ci});
    check({v.name, ".tag"}, {28'd0, dcpu_tag_o},        {28'd0, v.e_tag});
    check({v.name, ".err"}, {31'd0, dcpu_err_o},        {31'd0, v.e_err});
  endtask

  task automatic spr_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    spr_cs    = 1'b1;
    spr_write = 1'b1;
    spr_addr  = addr;
    spr_dat_i = data;
    #2;
    check("spr_dat_o during write", spr_dat_o, 32'h0);
    @(negedge clk);
    spr_cs    = 1'b0;
    spr_write = 1'b0;
  endtask

  task automatic spr_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    spr_cs    = 1'b1;
    spr_write = 1'b0;
    spr_addr  = addr;
    #2;
    check(name, spr_dat_o, exp);
    @(negedge clk);
    spr_cs = 1'b0;
  endtask

  initial begin
    //             name   en   dce  sv   we   cyc  adr            qtag  qerr e_adr          e_cyc e_ci e_tag e_err
    tab_a[0] = '{"pass",  1'b0,1'b1,1'b1,1'b0,1'b1,32'h0000_0013, 4'h1,1'b0,32'h0000_0013, 1'b1,1'b0,4'h1,1'b0};
    tab_a[1] = '{"miss0", 1'b1,1'b1,1'b1,1'b0,1'b1,32'h0000_0002, 4'h1,1'b0,32'h0000_0002, 1'b0,1'b0,4'hD,1'b1};
    tab_a[2] = '{"pass_ci",1'b0,1'b0,1'b0,1'b1,1'b1,32'hFFFF_FFFF,4'h7,1'b0,32'hFFFF_FFFF, 1'b1,1'b1,4'h7,1'b0};

    tab_b[0]  = '{"hit0",    1'b1,1'b1,1'b1,1'b0,1'b1,32'h0000_0013,4'h1,1'b0,32'h0004_0013,1'b1,1'b0,4'h1,1'b0};
    tab_b[1]  = '{"pf_swe",  1'b1,1'b1,1'b1,1'b1,1'b1,32'h8000_2055,4'h1,1'b0,32'h0024_6055,1'b0,1'b0,4'hB,1'b1};
    tab_b[2]  = '{"ok_sre",  1'b1,1'b1,1'b1,1'b0,1'b1,32'h8000_2055,4'h3,1'b0,32'h0024_6055,1'b1,1'b0,4'h3,1'b0};
    tab_b[3]  = '{"pf_ure",  1'b1,1'b1,1'b0,1'b0,1'b1,32'h8000_2055,4'h3,1'b0,32'h0024_6055,1'b0,1'b0,4'hB,1'b1};
    tab_b[4]  = '{"ok_uwe",  1'b1,1'b1,1'b0,1'b1,1'b1,32'h0000_4ABC,4'h2,1'b0,32'hFFFF_EABC,1'b1,1'b1,4'h2,1'b0};
    tab_b[5]  = '{"pf_sre2", 1'b1,1'b1,1'b1,1'b0,1'b1,32'h0000_4ABC,4'h2,1'b0,32'hFFFF_EABC,1'b0,1'b1,4'hB,1'b1};
    tab_b[6]  = '{"qerr",    1'b1,1'b1,1'b1,1'b0,1'b1,32'h0000_0013,4'h5,1'b1,32'h0004_0013,1'b1,1'b0,4'h5,1'b1};
    tab_b[7]  = '{"miss_vpn",1'b1,1'b1,1'b1,1'b0,1'b1,32'h0008_0013,4'h5,1'b0,32'h0004_0013,1'b0,1'b0,4'hD,1'b1};
    tab_b[8]  = '{"pf_nocyc",1'b1,1'b1,1'b1,1'b1,1'b0,32'h8000_2055,4'h6,1'b0,32'h0024_6055,1'b0,1'b0,4'h6,1'b0};
    tab_b[9]  = '{"dc_off",  1'b1,1'b0,1'b1,1'b0,1'b1,32'h0000_1FFF,4'h0,1'b0,32'h0004_1FFF,1'b1,1'b1,4'h0,1'b0};
    tab_b[10] = '{"miss_nocyc",1'b1,1'b1,1'b1,1'b0,1'b0,32'h0008_0013,4'h9,1'b0,32'h0004_0013,1'b0,1'b0,4'h9,1'b0};

    rst = 1'b1; dc_en = 1'b1; dmmu_en = 1'b0; supv = 1'b1;
    dcpu_adr_i = '0; dcpu_cycstb_i = 1'b0; dcpu_we_i = 1'b0;
    spr_cs = 1'b0; spr_write = 1'b0; spr_addr = '0; spr_dat_i = '0;
    qmemdmmu_err_i = 1'b0; qmemdmmu_tag_i = 4'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset spr_dat_o", spr_dat_o, 32'h0);
    spr_rd("reset MR0", 32'h200, 32'h0);
    spr_rd("reset TR0", 32'h280, 32'h0);

    for (int i = 0; i < 3; i++) apply_vec(tab_a[i]);

    // Unmapped SPR address
    spr_wr(32'd10, 32'hACAC_01F1);
    spr_rd("unmapped rd", 32'd10, 32'h0);
    spr_rd("unmapped MR0", 32'h200, 32'h0);
    spr_rd("unmapped TR0", 32'h280, 32'h0);

    // Program entries
    spr_wr(32'h200, 32'h0000_0001);
    spr_wr(32'h280, 32'h0004_03C0);
    spr_wr(32'h201, 32'h8000_2001);
    spr_wr(32'h281, 32'h0024_6100);
    spr_wr(32'h202, 32'h0000_4001);
    spr_wr(32'h282, 32'hFFFF_E0C2);
    spr_wr(32'h203, 32'hFFFF_FFFF);
    spr_wr(32'h283, 32'hFFFF_FFFF);
    spr_rd("rd MR0", 32'h200, 32'h0000_0001);
    spr_rd("rd TR0", 32'h280, 32'h0004_03C0);
    spr_rd("rd MR3 mask", 32'h203, 32'hFFFF_E001);
    spr_rd("rd TR3 mask", 32'h283, 32'hFFFF_E3C2);

    for (int i = 0; i < 11; i++) apply_vec(tab_b[i]);

    // Write and lookup on the same entry in the same cycle
    @(negedge clk);
    dmmu_en = 1'b1; dc_en = 1'b1; supv = 1'b1; dcpu_we_i = 1'b0;
    dcpu_cycstb_i = 1'b1; dcpu_adr_i = 32'h0000_0013;
    qmemdmmu_err_i = 1'b0; qmemdmmu_tag_i = 4'h1;
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'h200; spr_dat_i = 32'h0;
    #2;
    check("same-cycle old hit", {31'd0, qmemdmmu_cycstb_o}, 32'd1);
    @(negedge clk);
    spr_cs = 1'b0; spr_write = 1'b0;
    #2;
    check("next-cycle miss tag", {28'd0, dcpu_tag_o}, 32'hD);
    check("next-cycle miss cyc", {31'd0, qmemdmmu_cycstb_o}, 32'd0);

    // Re-validate, then reset in the middle of an access
    spr_wr(32'h200, 32'h0000_0001);
    #2;
    check("revalid hit", {31'd0, qmemdmmu_cycstb_o}, 32'd1);
    check("revalid tag", {28'd0, dcpu_tag_o}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("pre-reset-edge hit", {31'd0, qmemdmmu_cycstb_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post-reset tag", {28'd0, dcpu_tag_o}, 32'hD);
    check("post-reset err", {31'd0, dcpu_err_o}, 32'd1);
    check("post-reset cyc", {31'd0, qmemdmmu_cycstb_o}, 32'd0);
    dcpu_cycstb_i = 1'b0;
    spr_rd("post-reset TR0", 32'h280, 32'h0);
    spr_rd("post-reset MR1", 32'h201, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/or1200_dmmu_top.md
Name: or1200_dmmu_top

Overview:
Data MMU for the OR1200 load/store path. It holds a direct-mapped, single-way data TLB (DTLB) that is programmed through SPR accesses. It translates CPU virtual data addresses to physical addresses for the QMEM/data-cache interface. It also flags TLB misses and page-protection faults back to the CPU through the tag and error outputs.

Parameters:
aw, 32, address width of the CPU and QMEM address buses.
dtlb_sets, 64, number of TLB entries; index width is log2(dtlb_sets) = 6.
page_bits, 13, page-offset width (8 KB pages).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
dc_en  in  1  data cache enabled.
dmmu_en  in  1  translation enabled.
supv  in  1  1 = supervisor mode, 0 = user mode.
dcpu_adr_i  in  aw  CPU virtual data address.
dcpu_cycstb_i  in  1  CPU access request (cycle/strobe).
dcpu_we_i  in  1  1 = store, 0 = load.
dcpu_tag_o  out  4  access tag returned to the CPU.
dcpu_err_o  out  1  access error to the CPU.
spr_cs  in  1  SPR chip select for the DMMU group.
spr_write  in  1  1 = SPR write, 0 = SPR read.
spr_addr  in  32  SPR address.
spr_dat_i  in  32  SPR write data.
spr_dat_o  out  32  SPR read data.
qmemdmmu_err_i  in  1  error from the downstream memory.
qmemdmmu_tag_i  in  4  tag from the downstream memory.
qmemdmmu_adr_o  out  aw  physical address to the downstream memory.
qmemdmmu_cycstb_o  out  1  request to the downstream memory.
qmemdmmu_ci_o  out  1  cache-inhibit flag to the downstream memory.

Behaviour:
- Each entry has two registers.
  - Match register (MR): VPN[31:13], V[0].
  - Translate register (TR): PPN[31:13], SWE[9], SRE[8], UWE[7], URE[6], CI[1].
  - All other bits read as 0.
- SPR decode:
  - TLB selected when spr_cs=1 and spr_addr[9]=1.
  - spr_addr[7]=0 selects MR, 1 selects TR.
  - spr_addr[5:0] is the entry index.
  - Any other address: reads return 0 and writes are ignored (e.g. spr_addr=10).
- SPR write: on a clock edge with spr_cs=1, spr_write=1 and the TLB selected, the addressed register is loaded from spr_dat_i; bits with no field are discarded.
- SPR read: combinational. spr_dat_o = addressed register when spr_cs=1, spr_write=0 and the TLB selected; otherwise 0.
- Reset: all MR/TR registers are cleared, so every entry is invalid.
- Lookup is combinational; the access completes in zero added cycles.
  - Index = dcpu_adr_i[18:13].
  - hit = MR.V & (MR.VPN == dcpu_adr_i[31:13]).
- Permission check, with dmmu_en=1 and hit:
  - supv=1: store needs SWE, load needs SRE.
  - supv=0: store needs UWE, load needs URE.
  - Failing the check is a page fault (pf).
- dmmu_en=1:
  - qmemdmmu_adr_o = {TR.PPN, dcpu_adr_i[12:0]}.
  - qmemdmmu_cycstb_o = dcpu_cycstb_i & hit & ~pf.
  - qmemdmmu_ci_o = ~dc_en | TR.CI.
- dmmu_en=0:
  - qmemdmmu_adr_o = dcpu_adr_i.
  - qmemdmmu_cycstb_o = dcpu_cycstb_i.
  - qmemdmmu_ci_o = ~dc_en.
- dcpu_tag_o, in priority order:
  - 4'hD on miss (dmmu_en & dcpu_cycstb_i & ~hit).
  - else 4'hB on pf with dcpu_cycstb_i.
  - else qmemdmmu_tag_i.
- dcpu_err_o = miss | (pf & dcpu_cycstb_i) | qmemdmmu_err_i.
- Outputs immediately after reset:
  - spr_dat_o = 0.
  - With dmmu_en=1 and dcpu_cycstb_i=1: miss, so dcpu_tag_o = 4'hD, dcpu_err_o = 1, qmemdmmu_cycstb_o = 0.
  - With dmmu_en=0: pass-through.
- Simultaneous SPR write and lookup to the same entry: the lookup uses the pre-write contents; the new value is visible the next cycle.
- Reset asserted mid-access invalidates all entries at that edge. No partial state is retained.
- Addresses wrap modulo 2^aw; no range checks.

Test Plan:
1. Reset, then dmmu_en=0, dc_en=1, dcpu_adr_i=13, cycstb=1 -> qmemdmmu_adr_o=13, qmemdmmu_cycstb_o=1, ci_o=0, err=0, tag = qmemdmmu_tag_i (1).
2. SPR write to spr_addr=10 with data ACAC01F1 -> read back at spr_addr=10 gives 0; TLB contents unchanged.
3. Write MR[0]=0x00000001 (addr 0x200) and TR[0]=0x0004_03C0 (addr 0x280: PPN=0x20, all permissions) -> then dmmu_en=1, dcpu_adr_i=0x0000_0013 -> qmemdmmu_adr_o=0x0004_0013, cycstb_o=1, err=0. Read 0x280 returns 0x0004_03C0.
4. dmmu_en=1 with TLB cleared by reset, dcpu_adr_i=2, cycstb=1 -> tag=0xD, err=1, cycstb_o=0.
5. Entry with only SRE set, supv=1, we=1 -> tag=0xB, err=1, cycstb_o=0. With we=0 the access passes.
6. TR.CI=1 with dc_en=1 -> ci_o=1. qmemdmmu_err_i=1 on a hit -> dcpu_err_o=1. Reset mid-sequence -> next lookup misses.
